tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Shares the single serial TX command channel between the instruction scheduler and the prefetch unit, and routes each returning RX reply to the requester that asked for it. It sits between the two requesters and the TX/RX engines. It holds one grant at a time, honours the scheduler's reservation across the address and data stages, and tracks outstanding replies in a small owner FIFO.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 2: depth of the reply-owner FIFO. Must be a power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `sched_valid` in 1: scheduler command request. Held stable until `sched_started`.
- `sched_cmd` in `` `TX_CMD_BITS ``: scheduler command header.
- `sched_reply_wanted` in 1: scheduler expects an RX reply to this command.
- `sched_reserve` in 1: scheduler reserves the channel; prefetch must not be granted.
- `sched_started` out 1: one-cycle pulse when the scheduler command is accepted by TX.
- `pf_valid` in 1: prefetch read request. Always `` `TX_HEADER_READ_16 ``, always wants a reply.
- `pf_started` out 1: one-cycle pulse when the prefetch command is accepted by TX.
- `tx_command_valid` out 1: to TX engine.
- `tx_command` out `` `TX_CMD_BITS ``: to TX engine.
- `tx_command_started` in 1: TX engine accepted the presented command.
- `tx_done` in 1: TX payload complete.
- `rx_started` in 1: first cycle of an RX message.
- `rx_done` in 1: last cycle of an RX message.
- `rx_to_sched` out 1: current RX message belongs to the scheduler.
- `rx_to_pf` out 1: current RX message belongs to prefetch.
- `replies_pending` out 1: owner FIFO is non-empty.

## Operation
- State machine with three states: IDLE, GRANT_SCHED, GRANT_PF.
- IDLE: selects a requester using combinational arbitration on the current inputs.
  - Scheduler is eligible when `sched_valid` is high and its reply can be queued: either `sched_reply_wanted` is 0 or the FIFO is not full.
  - Prefetch is eligible when `pf_valid` is high, `sched_reserve` is 0, and the FIFO is not full.
  - If both are eligible, the scheduler wins, subject to Configuration.
  - `tx_command_valid` is driven high in the same cycle, with the winner's command.
- When `tx_command_started` arrives:
  - Pulse the winner's `*_started`.
  - Push the winner's owner bit (0 = sched, 1 = pf) into the FIFO if a reply is wanted.
  - Enter GRANT_<winner>.
- GRANT_x: `tx_command_valid` is 0. Return to IDLE on `tx_done`. No new grant is issued in that same cycle.
- If a request drops before `tx_command_started`, the arbiter simply re-arbitrates. This is a protocol violation for the scheduler but must not hang the arbiter.
- RX routing:
  - On `rx_started` with the FIFO non-empty, pop the head into the `rx_owner` register and set `rx_busy`.
  - `rx_to_sched`/`rx_to_pf` = `rx_busy` qualified by `rx_owner`. Both are also valid in the `rx_started` cycle, decoded from the FIFO head.
  - `rx_busy` clears on `rx_done`.
  - `rx_started` with the FIFO empty is an unsolicited message. Neither route output is asserted.
- A FIFO push and pop in the same cycle both take effect; occupancy is unchanged.
- Occupancy counter width: $clog2(`MAX_OUTSTANDING`)+1. Read and write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; FIFO empty; `rx_busy` 0.
  - Fairness counter (if compiled in) 0.
- Reset asserted mid-transaction drops the grant and the FIFO in that cycle. Replies still in flight afterwards are treated as unsolicited.
- Request-to-`tx_command_valid` latency: 0 cycles, combinational in IDLE.
- `*_started` is high exactly in the cycle of `tx_command_started`.
- Minimum spacing between two grants: `tx_done` cycle + 1.
- `rx_done` and `rx_started` for the next message in the same cycle: the new head is popped and `rx_busy` stays 1.
- A push when full can never occur, because eligibility gates on full.

## Configuration
- `TX_ARB_FAIR_EN` defined:
  - A 2-bit counter counts consecutive scheduler grants made while prefetch was also eligible.
  - When the counter reaches 3, prefetch wins the next contested IDLE arbitration, unless `sched_reserve` is high. The counter then clears.
  - The counter also clears on any prefetch grant.
- Not defined: strict scheduler priority and no counter logic.

## Test plan
- Single scheduler read with reply: `sched_valid`=1 and `sched_reply_wanted`=1 from reset; TX starts 2 cycles later.
  - Expect `tx_command_valid`=1 immediately, `sched_started` pulse, `replies_pending`=1.
  - Later `rx_started` gives `rx_to_sched`=1 until `rx_done`; `replies_pending` returns to 0.
- Reservation: `sched_reserve`=1 with `pf_valid`=1 for 10 cycles → no `pf_started`. Release → `pf_started` within 1 cycle of `tx_command_started`.
- Full FIFO (`MAX_OUTSTANDING`=2): two prefetch grants without RX, then a third `pf_valid` → `tx_command_valid` stays 0.
  - After one `rx_done`, the third request is granted.
- Ordering: sched grant then pf grant; two RX messages → first routes `rx_to_sched`, second `rx_to_pf`.
- Simultaneous `rx_started` pop and `tx_command_started` push with occupancy 1 → occupancy stays 1 and the correct owner is routed.
- With `TX_ARB_FAIR_EN`, both requesting continuously with `sched_reply_wanted`=0 → grant sequence S,S,S,P repeats.
  - Without the macro → S only.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: the TX/RX handshake bundle between the two requesters
// (scheduler, prefetch), the TX/RX engines and tx_arbiter.
//   slave  modport: the arbiter's view (requests/engine status in, grants/routes out)
//   master modport: the environment's view (the mirror image)
// Signals:
//   sched_valid, sched_cmd, sched_reply_wanted, sched_reserve -> scheduler request
//   sched_started                                             <- scheduler accepted
//   pf_valid                                                  -> prefetch read request
//   pf_started                                                <- prefetch accepted
//   tx_command_valid, tx_command                              <- to TX engine
//   tx_command_started, tx_done                               -> from TX engine
//   rx_started, rx_done                                       -> from RX engine
//   rx_to_sched, rx_to_pf, replies_pending                    <- reply routing
// TX_CMD_BITS / TX_HEADER_READ_16 get defaults here unless the build supplies them.

`ifndef TX_CMD_BITS
`define TX_CMD_BITS 16
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 16'h0510
`endif

interface tx_arbiter_if;
    logic                    sched_valid;
    logic [`TX_CMD_BITS-1:0] sched_cmd;
    logic                    sched_reply_wanted;
    logic                    sched_reserve;
    logic                    sched_started;
    logic                    pf_valid;
    logic                    pf_started;
    logic                    tx_command_valid;
    logic [`TX_CMD_BITS-1:0] tx_command;
    logic                    tx_command_started;
    logic                    tx_done;
    logic                    rx_started;
    logic                    rx_done;
    logic                    rx_to_sched;
    logic                    rx_to_pf;
    logic                    replies_pending;

    modport slave (
        input  sched_valid, sched_cmd, sched_reply_wanted, sched_reserve,
        input  pf_valid,
        input  tx_command_started, tx_done, rx_started, rx_done,
        output sched_started, pf_started, tx_command_valid, tx_command,
        output rx_to_sched, rx_to_pf, replies_pending
    );

    modport master (
        output sched_valid, sched_cmd, sched_reply_wanted, sched_reserve,
        output pf_valid,
        output tx_command_started, tx_done, rx_started, rx_done,
        input  sched_started, pf_started, tx_command_valid, tx_command,
        input  rx_to_sched, rx_to_pf, replies_pending
    );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the serial TX command channel between the instruction
// scheduler and the prefetch unit, and routes each RX reply back to the
// requester that issued the matching command via a small owner FIFO.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - tx_arbiter_if.slave (requests, TX handshake, RX routing)
// Parameter MAX_OUTSTANDING: owner FIFO depth (power of two, >= 2).
// Optional feature: define TX_ARB_FAIR_EN to let prefetch win one contested
// arbitration after three consecutive contested scheduler grants.
// Grant/started/route outputs are combinational by design: the TX request
// must appear in the same cycle as the requester's valid.

`ifndef TX_CMD_BITS
`define TX_CMD_BITS 16
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 16'h0510
`endif

module tx_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    tx_arbiter_if.slave  bus
);

    localparam int unsigned CMD_W = `TX_CMD_BITS;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_GRANT_SCHED = 2'd1,
        S_GRANT_PF    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;   // 0 = sched, 1 = pf
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       rx_owner_q, rx_owner_d;
    logic                       rx_busy_q, rx_busy_d;

    logic                       fifo_full_c;
    logic                       fifo_empty_c;
    logic                       head_c;
    logic                       sched_elig_c;
    logic                       pf_elig_c;
    logic                       pick_pf_c;
    logic                       fair_turn_c;
    logic                       push_c;
    logic                       push_owner_c;
    logic                       pop_c;
    logic                       tx_valid_c;
    logic [CMD_W-1:0]           tx_cmd_c;
    logic                       sched_started_c;
    logic                       pf_started_c;
    logic                       rx_to_sched_c;
    logic                       rx_to_pf_c;

`ifdef TX_ARB_FAIR_EN
    logic [1:0]                 fair_cnt_q, fair_cnt_d;
    assign fair_turn_c = (fair_cnt_q == 2'd3);
`else
    assign fair_turn_c = 1'b0;
`endif

    // State and FIFO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_owner_q <= 1'b0;
            rx_busy_q  <= 1'b0;
`ifdef TX_ARB_FAIR_EN
            fair_cnt_q <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_owner_q <= rx_owner_d;
            rx_busy_q  <= rx_busy_d;
`ifdef TX_ARB_FAIR_EN
            fair_cnt_q <= fair_cnt_d;
`endif
        end
    end

    // Arbitration, grant FSM, owner FIFO and RX routing
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        rx_owner_d      = rx_owner_q;
        rx_busy_d       = rx_busy_q;
`ifdef TX_ARB_FAIR_EN
        fair_cnt_d      = fair_cnt_q;
`endif
        tx_valid_c      = 1'b0;
        tx_cmd_c        = '0;
        sched_started_c = 1'b0;
        pf_started_c    = 1'b0;
        push_c          = 1'b0;
        push_owner_c    = 1'b0;

        fifo_full_c  = (count_q == CNT_W'(MAX_OUTSTANDING));
        fifo_empty_c = (count_q == '0);
        head_c       = owner_q[rd_ptr_q];

        // Eligibility gates on FIFO space so a push can never overflow
        sched_elig_c = bus.sched_valid && (!bus.sched_reply_wanted || !fifo_full_c);
        pf_elig_c    = bus.pf_valid && !bus.sched_reserve && !fifo_full_c;
        pick_pf_c    = pf_elig_c && (!sched_elig_c || fair_turn_c);

        unique case (state_q)
            S_IDLE: begin
                if (sched_elig_c || pf_elig_c) begin
                    tx_valid_c = 1'b1;
                    tx_cmd_c   = pick_pf_c ? CMD_W'(`TX_HEADER_READ_16) : bus.sched_cmd;
                    if (bus.tx_command_started) begin
                        if (pick_pf_c) begin
                            pf_started_c = 1'b1;
                            push_c       = 1'b1;
                            push_owner_c = 1'b1;
                            state_d      = S_GRANT_PF;
`ifdef TX_ARB_FAIR_EN
                            fair_cnt_d   = 2'd0;
`endif
                        end else begin
                            sched_started_c = 1'b1;
                            push_c          = bus.sched_reply_wanted;
                            state_d         = S_GRANT_SCHED;
`ifdef TX_ARB_FAIR_EN
                            if (pf_elig_c && (fair_cnt_q != 2'd3)) begin
                                fair_cnt_d = fair_cnt_q + 2'd1;
                            end
`endif
                        end
                    end
                end
            end
            S_GRANT_SCHED, S_GRANT_PF: begin
                if (bus.tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Owner FIFO: push on accepted command, pop on each solicited RX start
        pop_c = bus.rx_started && !fifo_empty_c;
        if (push_c) begin
            owner_d[wr_ptr_q] = push_owner_c;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rx_owner_d = head_c;
            rx_busy_d  = 1'b1;
        end else if (bus.rx_done || bus.rx_started) begin
            rx_busy_d  = 1'b0;
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // In the start cycle the route comes straight from the FIFO head
        if (bus.rx_started) begin
            rx_to_sched_c = pop_c && !head_c;
            rx_to_pf_c    = pop_c && head_c;
        end else begin
            rx_to_sched_c = rx_busy_q && !rx_owner_q;
            rx_to_pf_c    = rx_busy_q && rx_owner_q;
        end
    end

    assign bus.tx_command_valid = tx_valid_c;
    assign bus.tx_command       = tx_cmd_c;
    assign bus.sched_started    = sched_started_c;
    assign bus.pf_started       = pf_started_c;
    assign bus.rx_to_sched      = rx_to_sched_c;
    assign bus.rx_to_pf         = rx_to_pf_c;
    assign bus.replies_pending  = !fifo_empty_c;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: self-checking bench for tx_arbiter (MAX_OUTSTANDING = 2).
// Every reply the bench expects is queued with its owner when a grant is
// accepted and popped when the RX engine starts a message. Inputs are driven
// on the falling edge; outputs are sampled 1 ns later.

`ifndef TX_CMD_BITS
`define TX_CMD_BITS 16
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 16'h0510
`endif

module tb_tx_arbiter;

    localparam int unsigned CMD_W = `TX_CMD_BITS;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    bit   exp_q[$];     // expected reply owners, 0 = sched, 1 = pf

    tx_arbiter_if bus ();

    tx_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] route_of(input bit have, input bit owner);
        if (!have) return 2'b00;
        return owner ? 2'b01 : 2'b10;
    endfunction

    // Full grant: present, optional hold, accept, transfer, done.
    task automatic grant(input bit is_pf, input bit reply, input int delay, input bit drop);
        logic [CMD_W-1:0] exp_cmd;
        exp_cmd = is_pf ? CMD_W'(`TX_HEADER_READ_16) : bus.sched_cmd;
        #1;
        check(is_pf ? "pf_cmd_valid" : "sched_cmd_valid", 32'(bus.tx_command_valid), 32'(1));
        check(is_pf ? "pf_tx_command" : "sched_tx_command", 32'(bus.tx_command), 32'(exp_cmd));
        repeat (delay) begin
            @(negedge clk); #1;
            check("valid_hold", 32'(bus.tx_command_valid), 32'(1));
            check("no_early_start", 32'({bus.sched_started, bus.pf_started}), 32'(0));
        end
        @(negedge clk);
        bus.tx_command_started = 1'b1;
        #1;
        check("started_pulse", 32'({bus.sched_started, bus.pf_started}),
              is_pf ? 32'(2'b01) : 32'(2'b10));
        if (reply) exp_q.push_back(is_pf);
        @(negedge clk);
        bus.tx_command_started = 1'b0;
        if (drop) begin
            if (is_pf) bus.pf_valid = 1'b0;
            else       bus.sched_valid = 1'b0;
        end
        #1;
        check("grant_valid_low", 32'(bus.tx_command_valid), 32'(0));
        check("started_cleared", 32'({bus.sched_started, bus.pf_started}), 32'(0));
        check("pending_after_grant", 32'(bus.replies_pending), 32'(exp_q.size() != 0));
        @(negedge clk);
        bus.tx_done = 1'b1;
        #1;
        check("done_cycle_no_grant", 32'(bus.tx_command_valid), 32'(0));
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    // RX message of len body cycles; route compared against the scoreboard head.
    task automatic rx_msg(input int len);
        bit         have;
        bit         owner;
        logic [1:0] exp_route;
        have  = (exp_q.size() != 0);
        owner = 1'b0;
        if (have) owner = exp_q.pop_front();
        exp_route = route_of(have, owner);
        bus.rx_started = 1'b1;
        #1;
        check("rx_route_start", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(exp_route));
        @(negedge clk);
        bus.rx_started = 1'b0;
        repeat (len) begin
            #1;
            check("rx_route_body", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(exp_route));
            @(negedge clk);
        end
        bus.rx_done = 1'b1;
        #1;
        check("rx_route_done", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(exp_route));
        @(negedge clk);
        bus.rx_done = 1'b0;
        #1;
        check("rx_route_idle", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(0));
        check("pending_after_rx", 32'(bus.replies_pending), 32'(exp_q.size() != 0));
        @(negedge clk);
    endtask

    initial begin
        bit exp_pf;
        n_checks               = 0;
        n_errors               = 0;
        reset                  = 1'b1;
        bus.sched_valid        = 1'b0;
        bus.sched_cmd          = '0;
        bus.sched_reply_wanted = 1'b0;
        bus.sched_reserve      = 1'b0;
        bus.pf_valid           = 1'b0;
        bus.tx_command_started = 1'b0;
        bus.tx_done            = 1'b0;
        bus.rx_started         = 1'b0;
        bus.rx_done            = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'({bus.tx_command_valid, bus.sched_started, bus.pf_started,
                                    bus.rx_to_sched, bus.rx_to_pf, bus.replies_pending}), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Single scheduler read with reply, TX accepts two cycles later
        bus.sched_cmd          = CMD_W'(16'h1234);
        bus.sched_reply_wanted = 1'b1;
        bus.sched_valid        = 1'b1;
        grant(1'b0, 1'b1, 2, 1'b1);
        rx_msg(3);

        // Reservation blocks prefetch, release grants it
        bus.sched_reserve = 1'b1;
        bus.pf_valid      = 1'b1;
        repeat (10) begin
            #1;
            check("reserve_blocks_pf", 32'({bus.tx_command_valid, bus.pf_started}), 32'(0));
            @(negedge clk);
        end
        bus.sched_reserve = 1'b0;
        grant(1'b1, 1'b1, 0, 1'b1);
        rx_msg(1);

        // Fill the FIFO with two prefetch reads, third request must wait
        bus.pf_valid = 1'b1;
        grant(1'b1, 1'b1, 0, 1'b0);
        grant(1'b1, 1'b1, 0, 1'b0);
        repeat (4) begin
            #1;
            check("full_blocks_pf", 32'(bus.tx_command_valid), 32'(0));
            @(negedge clk);
        end
        bus.sched_cmd          = CMD_W'(16'hBEEF);
        bus.sched_reply_wanted = 1'b1;
        bus.sched_valid        = 1'b1;
        #1;
        check("full_blocks_sched_reply", 32'(bus.tx_command_valid), 32'(0));
        @(negedge clk);
        bus.sched_reply_wanted = 1'b0;
        #1;
        check("full_allows_sched_noreply", 32'({bus.tx_command_valid, bus.tx_command}),
              32'({1'b1, CMD_W'(16'hBEEF)}));
        @(negedge clk);
        bus.sched_valid = 1'b0;
        #1;
        check("full_idle_again", 32'(bus.tx_command_valid), 32'(0));
        @(negedge clk);
        rx_msg(2);
        grant(1'b1, 1'b1, 0, 1'b1);
        rx_msg(1);
        rx_msg(1);

        // Ordering: sched then pf, replies route back in the same order
        bus.sched_cmd          = CMD_W'(16'h0A0B);
        bus.sched_reply_wanted = 1'b1;
        bus.sched_valid        = 1'b1;
        bus.pf_valid           = 1'b1;
        grant(1'b0, 1'b1, 1, 1'b1);
        grant(1'b1, 1'b1, 0, 1'b1);
        rx_msg(1);
        rx_msg(2);

        // Same-cycle pop and push with one reply outstanding
        bus.sched_cmd          = CMD_W'(16'h7777);
        bus.sched_reply_wanted = 1'b1;
        bus.sched_valid        = 1'b1;
        grant(1'b0, 1'b1, 0, 1'b1);
        bus.pf_valid = 1'b1;
        #1;
        check("simul_pf_present", 32'({bus.tx_command_valid, bus.tx_command}),
              32'({1'b1, CMD_W'(`TX_HEADER_READ_16)}));
        @(negedge clk);
        exp_pf = exp_q.pop_front();
        exp_q.push_back(1'b1);
        bus.rx_started         = 1'b1;
        bus.tx_command_started = 1'b1;
        #1;
        check("simul_route_start", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(route_of(1'b1, exp_pf)));
        check("simul_pf_started", 32'({bus.sched_started, bus.pf_started}), 32'(2'b01));
        @(negedge clk);
        bus.rx_started         = 1'b0;
        bus.tx_command_started = 1'b0;
        bus.pf_valid           = 1'b0;
        #1;
        check("simul_route_body", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(route_of(1'b1, exp_pf)));
        check("simul_pending", 32'(bus.replies_pending), 32'(1));
        check("simul_granted", 32'(bus.tx_command_valid), 32'(0));
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.tx_done = 1'b1;
        #1;
        check("simul_route_done", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(route_of(1'b1, exp_pf)));
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        #1;
        check("simul_route_idle", 32'({bus.rx_to_sched, bus.rx_to_pf}), 32'(0));
        @(negedge clk);
        rx_msg(1);

        // Scheduler command with no reply, then an unsolicited RX message
        bus.sched_cmd          = CMD_W'(16'h00C3);
        bus.sched_reply_wanted = 1'b0;
        bus.sched_valid        = 1'b1;
        grant(1'b0, 1'b0, 0, 1'b1);
        rx_msg(1);

        // Both requesting continuously, no scheduler replies
        bus.sched_cmd          = CMD_W'(16'h5151);
        bus.sched_reply_wanted = 1'b0;
        bus.sched_valid        = 1'b1;
        bus.pf_valid           = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef TX_ARB_FAIR_EN
            exp_pf = ((i % 4) == 3);
`else
            exp_pf = 1'b0;
`endif
            grant(exp_pf, exp_pf, 0, 1'b0);
        end
        bus.sched_valid = 1'b0;
        bus.pf_valid    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() != 0) rx_msg(1);
        end

        // Reset during a grant drops the grant and the pending reply
        bus.pf_valid = 1'b1;
        #1;
        check("rst_mid_present", 32'(bus.tx_command_valid), 32'(1));
        @(negedge clk);
        bus.tx_command_started = 1'b1;
        @(negedge clk);
        bus.tx_command_started = 1'b0;
        bus.pf_valid           = 1'b0;
        #1;
        check("rst_mid_pending", 32'(bus.replies_pending), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_cleared", 32'({bus.tx_command_valid, bus.replies_pending}), 32'(0));
        @(negedge clk);
        rx_msg(1);
        bus.pf_valid = 1'b1;
        grant(1'b1, 1'b1, 0, 1'b1);
        rx_msg(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
